// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared types and helpers for the streaming 2-D convolution
//                engine (FSM state encoding, accumulator width derivation).
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    // Engine states: take pixels, run the KxK taps, present a result.
    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_MAC    = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    // Width of an accumulator that can sum K*K full-scale signed products
    // (zero-extended pixel times signed weight) without wrapping.
    function automatic int acc_width(input int data_w, input int weight_w, input int k);
        return data_w + weight_w + 1 + $clog2(k * k);
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_line_buffer
//  Description : K-1 row delay lines of IMG_W pixels feeding a KxK sliding
//                window. One push shifts a new column into the window; tap
//                (r,c) of the flat output sits at index r*K+c, row 0 oldest.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_line_buffer #(
    parameter int IMG_W  = 28,
    parameter int K      = 5,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    output logic [K*K*DATA_W-1:0]      win_o
);

    logic [DATA_W-1:0] fifo_q  [K-1][IMG_W];
    logic [DATA_W-1:0] fifo_in [K-1];
    logic [DATA_W-1:0] col_in  [K];
    logic [DATA_W-1:0] win_q   [K][K];

    // Delay line f is fed by the tail of line f-1; the newest column of the
    // window takes the live pixel at the bottom and older rows above it.
    always_comb begin
        fifo_in[0] = data_i;
        for (int f = 1; f < K - 1; f++) begin
            fifo_in[f] = fifo_q[f-1][IMG_W-1];
        end
        col_in[K-1] = data_i;
        for (int r = 0; r < K - 1; r++) begin
            col_in[r] = fifo_q[K-2-r][IMG_W-1];
        end
    end

    // Shift the row delay lines and the window by one pixel per push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < K - 1; f++) begin
                for (int j = 0; j < IMG_W; j++) begin
                    fifo_q[f][j] <= '0;
                end
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (push_i) begin
            for (int f = 0; f < K - 1; f++) begin
                fifo_q[f][0] <= fifo_in[f];
                for (int j = 1; j < IMG_W; j++) begin
                    fifo_q[f][j] <= fifo_q[f][j-1];
                end
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][K-1] <= col_in[r];
            end
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
            assign win_o[(r*K+c)*DATA_W +: DATA_W] = win_q[r][c];
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv2d_stream.sv
`default_nettype none
// ============================================================================
//  Module      : conv2d_stream
//  Description : Streaming KxK convolution, N_CH output channels sharing one
//                input plane. Raster pixels in over valid/ready, one tap per
//                cycle on all channels, optional ReLU, result out over
//                valid/ready with its output coordinates.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int K        = 5,
    parameter int N_CH     = 8,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [DATA_W-1:0]                                 in_data,
    input  logic                                              wr_en,
    input  logic [$clog2(N_CH)-1:0]                           wr_ch,
    input  logic [$clog2(K*K)-1:0]                            wr_idx,
    input  logic [WEIGHT_W-1:0]                               wr_data,
    input  logic                                              relu_en,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [N_CH*acc_width(DATA_W, WEIGHT_W, K)-1:0]    out_data,
    output logic [$clog2(IMG_W-K+1)-1:0]                      out_x,
    output logic [$clog2(IMG_H-K+1)-1:0]                      out_y,
    output logic                                              busy,
    output logic                                              frame_done
);

    localparam int ACC_W  = acc_width(DATA_W, WEIGHT_W, K);
    localparam int PROD_W = DATA_W + WEIGHT_W + 1;
    localparam int NT     = K * K;
    localparam int TW     = $clog2(NT);
    localparam int CHW    = $clog2(N_CH);
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int XW     = $clog2(IMG_W - K + 1);
    localparam int YW     = $clog2(IMG_H - K + 1);

    state_t                    state_q;
    logic [CW-1:0]             col_q;
    logic [RW-1:0]             row_q;
    logic [TW-1:0]             tap_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic [N_CH*ACC_W-1:0]     out_data_q;
    logic [XW-1:0]             out_x_q;
    logic [YW-1:0]             out_y_q;
    logic                      busy_q;
    logic                      frame_done_q;
    logic                      last_q;
    logic signed [WEIGHT_W-1:0] w_q  [N_CH][NT];
    logic signed [ACC_W-1:0]   acc_q [N_CH];

    logic signed [ACC_W-1:0]   acc_d [N_CH];
    logic signed [PROD_W-1:0]  prod  [N_CH];
    logic [N_CH*ACC_W-1:0]     out_d;
    logic [NT*DATA_W-1:0]      win;
    logic [DATA_W-1:0]         pix   [NT];
    logic                      accept;
    logic                      win_full;
    logic                      last_pix;

    assign accept   = in_valid && in_ready_q;
    assign win_full = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
    assign last_pix = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

    conv_line_buffer #(
        .IMG_W  (IMG_W),
        .K      (K),
        .DATA_W (DATA_W)
    ) u_line_buffer (
        .clk    (clk),
        .rst    (rst),
        .push_i (accept),
        .data_i (in_data),
        .win_o  (win)
    );

    for (genvar t = 0; t < NT; t++) begin : g_tap
        assign pix[t] = win[t*DATA_W +: DATA_W];
    end

    // One tap per cycle per lane: zero-extended pixel times signed weight.
    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        assign prod[c]  = PROD_W'($signed({1'b0, pix[tap_q]})) * PROD_W'(w_q[c][tap_q]);
        assign acc_d[c] = acc_q[c] + ACC_W'(prod[c]);
    end

    // Final tap result per channel, with optional clamp of negatives to zero.
    always_comb begin
        out_d = '0;
        for (int c = 0; c < N_CH; c++) begin
            out_d[c*ACC_W +: ACC_W] = (relu_en && acc_d[c][ACC_W-1]) ? '0 : acc_d[c];
        end
    end

    // Weight register file; writes only land between frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int t = 0; t < NT; t++) begin
                    w_q[c][t] <= '0;
                end
            end
        end else if (wr_en && !busy_q) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int t = 0; t < NT; t++) begin
                    if (wr_ch == CHW'(c) && wr_idx == TW'(t)) begin
                        w_q[c][t] <= wr_data;
                    end
                end
            end
        end
    end

    // Control FSM with raster counters, MAC accumulators and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ACCEPT;
            col_q        <= '0;
            row_q        <= '0;
            tap_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            last_q       <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                ST_ACCEPT: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (col_q == CW'(IMG_W - 1)) begin
                            col_q <= '0;
                            row_q <= (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                        if (win_full) begin
                            state_q    <= ST_MAC;
                            in_ready_q <= 1'b0;
                            tap_q      <= '0;
                            out_x_q    <= XW'(col_q - CW'(K - 1));
                            out_y_q    <= YW'(row_q - RW'(K - 1));
                            last_q     <= last_pix;
                            for (int c = 0; c < N_CH; c++) begin
                                acc_q[c] <= '0;
                            end
                        end
                    end
                end
                ST_MAC: begin
                    for (int c = 0; c < N_CH; c++) begin
                        acc_q[c] <= acc_d[c];
                    end
                    if (tap_q == TW'(NT - 1)) begin
                        state_q     <= ST_OUT;
                        out_valid_q <= 1'b1;
                        out_data_q  <= out_d;
                    end else begin
                        tap_q <= tap_q + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_q     <= ST_ACCEPT;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        if (last_q) begin
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                            last_q       <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_ACCEPT;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv2d_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv2d_stream
//  Description : Self-checking bench for conv2d_stream at 6x6, K=3, 2 ch.
//                Frame vectors come from a table; stall, mid-frame reset and
//                mid-frame weight write are hand-written sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2d_stream;

    localparam int AW = 21;   // 8 + 8 + 1 + clog2(9)

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        wr_en;
    logic [0:0]  wr_ch;
    logic [3:0]  wr_idx;
    logic [7:0]  wr_data;
    logic        relu_en;
    logic        out_valid;
    logic        out_ready;
    logic [41:0] out_data;
    logic [1:0]  out_x;
    logic [1:0]  out_y;
    logic        busy;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    conv2d_stream #(
        .IMG_W    (6),
        .IMG_H    (6),
        .K        (3),
        .N_CH     (2),
        .DATA_W   (8),
        .WEIGHT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .relu_en    (relu_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_x      (out_x),
        .out_y      (out_y),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Frame vector: pixel source, weights, relu, and expected per-channel
    // result as base + ky*y + kx*x (hand-derived for each vector).
    typedef struct {
        bit raster;
        int pc;
        int w [2][9];
        bit relu;
        int e [2][3];
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pix_of(input int vi, input int idx);
        return tv[vi].raster ? idx : tv[vi].pc;
    endfunction

    task automatic load_weights(input int vi);
        for (int c = 0; c < 2; c++) begin
            for (int t = 0; t < 9; t++) begin
                @(negedge clk);
                wr_en = 1'b1; wr_ch = 1'(c); wr_idx = 4'(t); wr_data = 8'(tv[vi].w[c][t]);
            end
        end
        // Out-of-range tap index: must not disturb any weight.
        @(negedge clk);
        wr_en = 1'b1; wr_ch = 1'b0; wr_idx = 4'd12; wr_data = 8'd100;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic check_result(input int vi, input int ridx);
        int x, y;
        logic signed [AW-1:0] a0, a1;
        x  = ridx % 4;
        y  = ridx / 4;
        a0 = out_data[AW-1:0];
        a1 = out_data[2*AW-1:AW];
        chk("out_x", int'(out_x), x);
        chk("out_y", int'(out_y), y);
        chk("ch0", a0, tv[vi].e[0][0] + tv[vi].e[0][1] * y + tv[vi].e[0][2] * x);
        chk("ch1", a1, tv[vi].e[1][0] + tv[vi].e[1][1] * y + tv[vi].e[1][2] * x);
    endtask

    // Drive one frame and consume its results. stall: hold out_ready low at
    // the first result for that many cycles. midwr: attempt a weight write
    // mid-frame. rst_at>=0: reset during the MAC of that result and return.
    task automatic run_frame(input int vi, input bit load, input int stall,
                             input bit midwr, input int rst_at);
        int pidx = 0, ridx = 0, cyc = 0, fd = 0, idle = 0;
        int stall_left = stall, stall_err = 0, excl = 0;
        int acc14 = -1000, first_ov = -1, mac_cnt = 0;
        bit done = 0, aborted = 0;
        logic [41:0] snap = '0;
        if (load) load_weights(vi);
        relu_en = tv[vi].relu;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (pidx < 36) begin
                in_valid = 1'b1; in_data = 8'(pix_of(vi, pidx));
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'b1;
            if (midwr && pidx == 20) begin
                wr_en = 1'b1; wr_ch = 1'b0; wr_idx = 4'd4; wr_data = 8'd50;
            end else begin
                wr_en = 1'b0;
            end
            if (rst_at >= 0 && ridx == rst_at && pidx > 14 && !in_ready && !out_valid)
                mac_cnt++;
            if (mac_cnt == 3) begin
                rst = 1'b1; in_valid = 1'b0; wr_en = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_out_valid", int'(out_valid), 0);
                chk("rst_in_ready", int'(in_ready), 1);
                chk("rst_busy", int'(busy), 0);
                aborted = 1; done = 1;
            end else begin
                if (in_ready && out_valid) excl++;
                if (frame_done) fd++;
                if (out_valid && first_ov < 0) first_ov = cyc;
                if (out_valid && stall_left > 0) begin
                    if (stall_left == stall) snap = out_data;
                    out_ready = 1'b0;
                    if (out_data != snap || in_ready) stall_err++;
                    stall_left--;
                end
                if (in_valid && in_ready) begin
                    if (pidx == 14) acc14 = cyc;
                    pidx++;
                end
                if (out_valid && out_ready) begin
                    check_result(vi, ridx);
                    ridx++;
                end
                if (ridx == 16) idle++;
                if (idle == 3 || cyc > 3000) done = 1;
            end
        end
        in_valid = 1'b0;
        wr_en    = 1'b0;
        if (!aborted) begin
            chk("result_count", ridx, 16);
            chk("frame_done_count", fd, 1);
            chk("busy_after", int'(busy), 0);
            chk("ready_valid_excl", excl, 0);
            chk("latency", first_ov - acc14, 10);
            if (stall > 0) begin
                chk("stall_hold_err", stall_err, 0);
                chk("stall_len", stall_left, 0);
            end
        end
    endtask

    initial begin
        for (int v = 0; v < 6; v++) begin
            tv[v].raster = 0; tv[v].pc = 0; tv[v].relu = 0;
            for (int c = 0; c < 2; c++) begin
                for (int t = 0; t < 9; t++) tv[v].w[c][t] = 0;
                for (int k = 0; k < 3; k++) tv[v].e[c][k] = 0;
            end
        end
        // 0: constant 1, ch0 all ones -> 9 everywhere
        tv[0].pc = 1;
        for (int t = 0; t < 9; t++) tv[0].w[0][t] = 1;
        tv[0].e[0][0] = 9;
        // 1: raster, ch0 box sum = 9*centre, ch1 centre -1
        tv[1].raster = 1;
        for (int t = 0; t < 9; t++) tv[1].w[0][t] = 1;
        tv[1].w[1][4] = -1;
        tv[1].e[0][0] = 63; tv[1].e[0][1] = 54; tv[1].e[0][2] = 9;
        tv[1].e[1][0] = -7; tv[1].e[1][1] = -6; tv[1].e[1][2] = -1;
        // 2: as 1 with relu: ch1 clamps to 0
        tv[2] = tv[1];
        tv[2].relu = 1;
        tv[2].e[1][0] = 0; tv[2].e[1][1] = 0; tv[2].e[1][2] = 0;
        // 3: full-scale extremes, no wrap
        tv[3].pc = 255;
        for (int t = 0; t < 9; t++) begin
            tv[3].w[0][t] = -128; tv[3].w[1][t] = 127;
        end
        tv[3].e[0][0] = -293760; tv[3].e[1][0] = 291465;
        // 4: tap ordering: ch0 top-left x2, ch1 top-right x3
        tv[4].raster = 1;
        tv[4].w[0][0] = 2; tv[4].w[1][2] = 3;
        tv[4].e[0][1] = 12; tv[4].e[0][2] = 2;
        tv[4].e[1][0] = 6;  tv[4].e[1][1] = 18; tv[4].e[1][2] = 3;
        // 5: weights cleared by reset -> all zero results
        tv[5].pc = 7;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; wr_en = 1'b0; wr_ch = '0;
        wr_idx = '0; wr_data = '0; relu_en = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data != 42'd0), 0);
        chk("reset_out_xy", int'({out_y, out_x}), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_frame_done", int'(frame_done), 0);

        for (int v = 0; v < 5; v++) run_frame(v, 1'b1, 0, 1'b0, -1);

        // Output back-pressure at the first result
        run_frame(1, 1'b1, 20, 1'b0, -1);

        // Reset during MAC of the fifth result, then a frame on reset weights
        run_frame(0, 1'b1, 0, 1'b0, 4);
        run_frame(5, 1'b0, 0, 1'b0, -1);

        // Reload and attempt a weight write mid-frame
        run_frame(0, 1'b1, 0, 1'b1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
